// File: rtl/nitta_spi_slave_pu.sv
// NITTA processing unit bridging the computational network to an external SPI master,
// plus the host-side SPI master driver that shares the system clock.
module nitta_spi_slave_pu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ATTR_WIDTH     = 4,
  parameter int SPI_DATA_WIDTH = 32,
  parameter int BUF_SIZE       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  sclk,
  input  logic                  cs
);
  localparam int AW = $clog2(BUF_SIZE);
  localparam int CW = $clog2(SPI_DATA_WIDTH + 1);
  localparam logic [AW-1:0] LAST = AW'(BUF_SIZE - 1);
  localparam logic [CW-1:0] FULL = CW'(SPI_DATA_WIDTH);

  logic [BUF_SIZE-1:0][DATA_WIDTH-1:0] transfer_in_buffer, send_buffer;
  logic [BUF_SIZE-1:0][DATA_WIDTH-1:0] receive_buffer, transfer_out_buffer;
  logic [AW-1:0]             wr_addr, oe_addr, spi_addr;
  logic [CW-1:0]             bit_cnt;
  logic [SPI_DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic                      sclk_q, cs_q, miso_q;
  logic                      cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic                      unused_attr;

  assign unused_attr = ^attr_in;
  assign attr_out    = '0;
  assign data_out    = signal_oe ? transfer_out_buffer[oe_addr] : '0;
  assign miso        = cs ? 1'b0 : miso_q;

  // sclk/cs are already in the clk domain, so edges are live vs. one-cycle-old values
  assign cs_fall   = cs_q & ~cs;
  assign cs_rise   = ~cs_q & cs;
  assign sclk_rise = ~sclk_q & sclk;
  assign sclk_fall = sclk_q & ~sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      transfer_in_buffer <= '0;
      wr_addr            <= '0;
      oe_addr            <= '0;
    end else begin
      if (signal_wr) begin
        transfer_in_buffer[wr_addr] <= data_in;
        wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + AW'(1);
      end
      if (signal_oe)
        oe_addr <= (oe_addr == LAST) ? '0 : oe_addr + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_buffer         <= '0;
      receive_buffer      <= '0;
      transfer_out_buffer <= '0;
      spi_addr            <= '0;
      bit_cnt             <= '0;
      tx_sr               <= '0;
      rx_sr               <= '0;
      sclk_q              <= 1'b0;
      cs_q                <= 1'b1;
      miso_q              <= 1'b0;
    end else begin
      sclk_q <= sclk;
      cs_q   <= cs;
      if (cs_fall) begin
        // same-cycle network write to this slot lands after this read
        tx_sr                 <= SPI_DATA_WIDTH'(transfer_in_buffer[spi_addr]);
        send_buffer[spi_addr] <= transfer_in_buffer[spi_addr];
        miso_q                <= transfer_in_buffer[spi_addr][DATA_WIDTH-1];
        bit_cnt               <= '0;
      end else if (cs_rise) begin
        if (bit_cnt == FULL) begin
          receive_buffer[spi_addr]      <= DATA_WIDTH'(rx_sr);
          transfer_out_buffer[spi_addr] <= DATA_WIDTH'(rx_sr);
          spi_addr <= (spi_addr == LAST) ? '0 : spi_addr + AW'(1);
        end
      end else if (!cs) begin
        if (sclk_rise) begin
          rx_sr   <= {rx_sr[SPI_DATA_WIDTH-2:0], mosi};
          bit_cnt <= bit_cnt + CW'(1);
        end else if (sclk_fall) begin
          tx_sr  <= tx_sr << 1;
          miso_q <= tx_sr[SPI_DATA_WIDTH-2];
        end
      end
    end
  end
endmodule

module spi_master_driver #(
  parameter int SCLK_HALFPERIOD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_transaction,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk,
  output logic        cs
);
  localparam logic [15:0] HP_M1 = 16'(SCLK_HALFPERIOD - 1);

  typedef enum logic [1:0] {M_IDLE, M_LOW, M_HIGH, M_END} mstate_t;
  mstate_t     state;
  logic [15:0] cnt;
  logic [4:0]  bits;
  logic [31:0] tx, rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= M_IDLE;
      cnt      <= '0;
      bits     <= '0;
      tx       <= '0;
      rx       <= '0;
      data_out <= '0;
      ready    <= 1'b0;
      mosi     <= 1'b0;
      sclk     <= 1'b0;
      cs       <= 1'b1;
    end else begin
      ready <= 1'b0;
      case (state)
        M_IDLE: if (start_transaction) begin
          tx    <= data_in;
          mosi  <= data_in[31];
          cs    <= 1'b0;
          cnt   <= '0;
          bits  <= '0;
          state <= M_LOW;
        end
        M_LOW: if (cnt == HP_M1) begin
          cnt   <= '0;
          sclk  <= 1'b1;
          state <= M_HIGH;
        end else cnt <= cnt + 16'd1;
        M_HIGH: begin
          // miso has been stable since the slave's last shift; sample at start of high phase
          if (cnt == '0) rx <= {rx[30:0], miso};
          if (cnt == HP_M1) begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (bits == 5'd31) state <= M_END;
            else begin
              bits  <= bits + 5'd1;
              tx    <= tx << 1;
              mosi  <= tx[30];
              state <= M_LOW;
            end
          end else cnt <= cnt + 16'd1;
        end
        M_END: if (cnt == HP_M1) begin
          cnt      <= '0;
          cs       <= 1'b1;
          mosi     <= 1'b0;
          data_out <= rx;
          ready    <= 1'b1;
          state    <= M_IDLE;
        end else cnt <= cnt + 16'd1;
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nitta_spi_slave_pu.sv
// Scoreboard bench: SPI master driver and network port stimulus push expectations,
// a negedge monitor pops them whenever ready or signal_oe presents a word.
module tb_nitta_spi_slave_pu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signal_wr = 1'b0, signal_oe = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  attr_in = '0;
  logic [31:0] data_out;
  logic [3:0]  attr_out;
  logic        miso, mosi, sclk, cs;
  logic        m_mosi, m_sclk, m_cs, m_ready, m_start = 1'b0;
  logic [31:0] m_tx = '0, m_rx;
  logic        bb = 1'b0, bb_cs = 1'b1, bb_sclk = 1'b0, bb_mosi = 1'b0;

  int checks = 0, failures = 0;
  logic [31:0] exp_spi[$];
  logic [31:0] exp_oe[$];

  always #5 clk = ~clk;

  assign cs   = bb ? bb_cs   : m_cs;
  assign sclk = bb ? bb_sclk : m_sclk;
  assign mosi = bb ? bb_mosi : m_mosi;

  nitta_spi_slave_pu #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SPI_DATA_WIDTH(32), .BUF_SIZE(10)) dut (
    .clk(clk), .rst(rst), .signal_wr(signal_wr), .data_in(data_in), .attr_in(attr_in),
    .signal_oe(signal_oe), .data_out(data_out), .attr_out(attr_out),
    .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs));

  spi_master_driver #(.SCLK_HALFPERIOD(1)) mst (
    .clk(clk), .rst(rst), .start_transaction(m_start), .data_in(m_tx), .data_out(m_rx),
    .ready(m_ready), .miso(miso), .mosi(m_mosi), .sclk(m_sclk), .cs(m_cs));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (m_ready) begin
      if (exp_spi.size() == 0) check("spi_unexpected", m_rx, 32'hxxxx_xxxx);
      else check("spi_rx", m_rx, exp_spi.pop_front());
    end
    if (signal_oe) begin
      if (exp_oe.size() == 0) check("oe_unexpected", data_out, 32'hxxxx_xxxx);
      else check("oe_data", data_out, exp_oe.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic net_write(input logic [31:0] w);
    signal_wr = 1'b1; data_in = w; tick(); signal_wr = 1'b0;
  endtask

  task automatic oe_read(input logic [31:0] e);
    exp_oe.push_back(e); signal_oe = 1'b1; tick(); signal_oe = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] send, input logic [31:0] e);
    bit seen = 1'b0;
    exp_spi.push_back(e);
    m_tx = send; m_start = 1'b1; tick(); m_start = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (m_ready) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      failures++;
      $display("FAIL xfer_timeout actual=no_ready required=ready send=%h", send);
    end
    repeat (3) tick();
  endtask

  task automatic bb_partial(input logic [15:0] bits);
    bb_cs = 1'b1; bb_sclk = 1'b0; bb = 1'b1; tick();
    bb_cs = 1'b0; tick(); tick();
    for (int i = 15; i >= 0; i--) begin
      bb_mosi = bits[i]; tick();
      bb_sclk = 1'b1; tick();
      bb_sclk = 1'b0;
    end
    tick();
    bb_cs = 1'b1; tick(); tick();
    bb = 1'b0; tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_data_out", data_out, 0);
    check("rst_attr_out", {28'd0, attr_out}, 0);
    check("rst_miso", {31'd0, miso}, 0);
    check("rst_m_cs", {31'd0, m_cs}, 1);
    check("rst_m_ready", {31'd0, m_ready}, 0);
    check("rst_m_rx", m_rx, 0);
    rst = 1'b0; tick();

    // empty transfer_out reads 0; ten pulses walk oe_addr round to 0
    for (int i = 0; i < 10; i++) oe_read(32'h0);

    net_write(32'hA1A2A3A4); tick();
    net_write(32'hB1B2B3B4); tick();
    signal_wr = 1'b1; data_in = 32'hC1C2C3C4; tick();
    data_in = 32'hD1D2D3D4; tick(); signal_wr = 1'b0;
    check("tin0", dut.transfer_in_buffer[0], 32'hA1A2A3A4);
    check("tin1", dut.transfer_in_buffer[1], 32'hB1B2B3B4);
    check("tin2", dut.transfer_in_buffer[2], 32'hC1C2C3C4);
    check("tin3", dut.transfer_in_buffer[3], 32'hD1D2D3D4);

    xfer(32'hA1A2A3A4, 32'hA1A2A3A4);
    check("rcv0", dut.receive_buffer[0], 32'hA1A2A3A4);
    check("tout0", dut.transfer_out_buffer[0], 32'hA1A2A3A4);
    check("send0", dut.send_buffer[0], 32'hA1A2A3A4);
    xfer(32'hB1B2B3B4, 32'hB1B2B3B4);
    xfer(32'hC1C2C3C4, 32'hC1C2C3C4);
    xfer(32'hD1D2D3D4, 32'hD1D2D3D4);
    xfer(32'hA1A2A3A4, 32'h0);
    check("rcv4", dut.receive_buffer[4], 32'hA1A2A3A4);

    oe_read(32'hA1A2A3A4); oe_read(32'hB1B2B3B4); oe_read(32'hC1C2C3C4);
    oe_read(32'hD1D2D3D4); oe_read(32'hA1A2A3A4);
    tick();
    check("oe_low_zero", data_out, 0);

    // 16-bit transaction is dropped; next full word uses the same slot
    bb_partial(16'hBEEF);
    check("partial_spi_addr", {28'd0, dut.spi_addr}, 5);
    check("partial_rcv5", dut.receive_buffer[5], 0);
    xfer(32'h55AA33CC, 32'h0);
    oe_read(32'h55AA33CC);

    // wr_addr is 4; seven more writes wrap round onto index 0
    for (int i = 4; i < 10; i++) net_write(32'h1000_0000 + i);
    net_write(32'hE0E0E0E0);
    check("wrap_tin0", dut.transfer_in_buffer[0], 32'hE0E0E0E0);
    check("wrap_tin9", dut.transfer_in_buffer[9], 32'h1000_0009);
    for (int i = 6; i < 10; i++) xfer(32'h6000_0000 + i, 32'h1000_0000 + i);
    xfer(32'h6000_0000, 32'hE0E0E0E0);
    for (int i = 6; i < 10; i++) oe_read(32'h6000_0000 + i);
    oe_read(32'h6000_0000);

    // reset in the middle of a transaction
    m_tx = 32'hCAFEF00D; m_start = 1'b1; tick(); m_start = 1'b0;
    repeat (20) tick();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    check("mid_rst_m_cs", {31'd0, m_cs}, 1);
    check("mid_rst_miso", {31'd0, miso}, 0);
    check("mid_rst_spi_addr", {28'd0, dut.spi_addr}, 0);
    check("mid_rst_bit_cnt", {26'd0, dut.bit_cnt}, 0);
    for (int i = 0; i < 10; i++) begin
      check("mid_rst_tin", dut.transfer_in_buffer[i], 0);
      check("mid_rst_tout", dut.transfer_out_buffer[i], 0);
      check("mid_rst_rcv", dut.receive_buffer[i], 0);
      check("mid_rst_send", dut.send_buffer[i], 0);
    end
    xfer(32'h12345678, 32'h0);
    oe_read(32'h12345678);

    repeat (4) tick();
    check("spi_queue_drained", exp_spi.size(), 0);
    check("oe_queue_drained", exp_oe.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
